// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32I/M execute stage.
// Holds the M-extension funct3 codes, forward selects, ALU op codes and writeback selects.
package rv_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_WB    = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  // MUL is treated as signed x signed; its low half is the same either way.
  function automatic logic md_a_signed(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_b_signed(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU; zero latency, no flow control.
module alu
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      sel,
  output logic [XLEN-1:0] y
);
  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] sh;
  assign sh = b[SHW-1:0];

  always_comb begin
    y = '0;
    case (sel)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_SLL:   y = a << sh;
      ALU_SLT:   y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:  y = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:   y = a ^ b;
      ALU_SRL:   y = a >> sh;
      ALU_SRA:   y = $unsigned($signed(a) >>> sh);
      ALU_OR:    y = a | b;
      ALU_AND:   y = a & b;
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end
endmodule

// File: rtl/brcomp.sv
// Combinational branch comparator; zero latency, no flow control.
module brcomp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            brun,
  output logic            breq,
  output logic            brlt
);
  assign breq = (a == b);
  assign brlt = brun ? (a < b) : ($signed(a) < $signed(b));
endmodule

// File: rtl/muldiv_iter.sv
// Iterative radix-2 RV32M unit: 1 accept + XLEN steps + 1 done cycle.
// busy requests a front-end stall; the result is held in DONE until ack or kill.
module muldiv_iter
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic            ack,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, b_q;
  md_op_e          op_q;
  logic            div_q, neg_q, neg_r, bzero_q;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum, rem_sh;
  logic [XLEN-1:0] sub;
  logic            ge;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quo, rem;

  assign a_neg = md_a_signed(op) & a[XLEN-1];
  assign b_neg = md_b_signed(op) & b[XLEN-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  // hi:lo doubles as product accumulator (multiply) or remainder:quotient (divide).
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign rem_sh  = {hi_q, lo_q[XLEN-1]};
  assign ge      = (rem_sh >= {1'b0, b_q});
  assign sub     = rem_sh[XLEN-1:0] - b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MD_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      MD_IDLE: begin
        busy = start;
        if (start && !kill) state_d = MD_BUSY;
      end
      MD_BUSY: begin
        busy = ~kill;
        if (kill)                          state_d = MD_IDLE;
        else if (cnt_q == CW'(XLEN - 1))   state_d = MD_DONE;
      end
      MD_DONE: begin
        done = 1'b1;
        if (kill || ack) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      op_q    <= MD_MUL;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      bzero_q <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start && !kill) begin
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= a_mag;
            b_q     <= b_mag;
            op_q    <= md_op_e'(op);
            div_q   <= op[2];
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            bzero_q <= (b == '0);
          end
        end
        MD_BUSY: begin
          if (!kill) begin
            cnt_q <= cnt_q + 1'b1;
            if (div_q) begin
              hi_q <= ge ? sub : rem_sh[XLEN-1:0];
              lo_q <= {lo_q[XLEN-2:0], ge};
            end else begin
              hi_q <= mul_sum[XLEN:1];
              lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Divide by zero bypasses sign fix-up: quotient is all ones, remainder the dividend.
  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? (~prod + 1'b1) : prod;
    quo    = bzero_q ? '1 : (neg_q ? (~lo_q + 1'b1) : lo_q);
    rem    = neg_r ? (~hi_q + 1'b1) : hi_q;
    result = '0;
    case (op_q)
      MD_MUL:                        result = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  result = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               result = quo;
      MD_REM, MD_REMU:               result = rem;
      default:                       result = '0;
    endcase
  end
endmodule

// File: rtl/ex_stage_md.sv
// RV32IM execute stage: forwarding, ALU, branch compare, iterative M unit, EX/MEM register.
// Single-cycle for base ops; an M-op holds EX for XLEN+2 cycles with stall_o high XLEN+1 of them.
module ex_stage_md
  import rv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter bit MD_EN = 1'b1,
  parameter int RSW_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [XLEN-1:0]  rs1_ex_i,
  input  logic [XLEN-1:0]  rs2_ex_i,
  input  logic [XLEN-1:0]  imm_ex_i,
  input  logic [XLEN-1:0]  pc_ex_i,
  input  logic [XLEN-1:0]  pc4_ex_i,
  input  logic [31:0]      inst_ex_i,
  input  logic [3:0]       alusel_ex_i,
  input  logic             asel_ex_i,
  input  logic             bsel_ex_i,
  input  logic             brun_ex_i,
  input  logic             memrw_ex_i,
  input  logic             regwen_ex_i,
  input  logic [1:0]       wbsel_ex_i,
  input  logic [RSW_W-1:0] rsw_ex_i,
  input  logic [1:0]       fwd_a_i,
  input  logic [1:0]       fwd_b_i,
  input  logic [XLEN-1:0]  data_wb_i,
  input  logic             md_valid_i,
  input  logic [2:0]       md_op_i,
  input  logic             enable_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             breq_o,
  output logic             brlt_o,
  output logic [XLEN-1:0]  alu_o,
  output logic [XLEN-1:0]  alu_mem_o,
  output logic [XLEN-1:0]  rs2_mem_o,
  output logic [XLEN-1:0]  pc4_mem_o,
  output logic             memrw_mem_o,
  output logic             regwen_mem_o,
  output logic [1:0]       wbsel_mem_o,
  output logic [RSW_W-1:0] rsw_mem_o,
  output logic [31:0]      inst_mem_o
);
  typedef struct packed {
    logic [XLEN-1:0]  alu;
    logic [XLEN-1:0]  rs2;
    logic [XLEN-1:0]  pc4;
    logic             memrw;
    logic             regwen;
    logic [1:0]       wbsel;
    logic [RSW_W-1:0] rsw;
    logic [31:0]      inst;
  } exmem_t;

  logic [XLEN-1:0] op_a, op_b, alu_a, alu_b, md_result;
  logic            md_busy, md_done;
  exmem_t          exmem_d, exmem_q;

  always_comb begin
    op_a = rs1_ex_i;
    case (fwd_a_i)
      FWD_EXMEM: op_a = alu_mem_o;
      FWD_WB:    op_a = data_wb_i;
      default:   op_a = rs1_ex_i;
    endcase
  end

  always_comb begin
    op_b = rs2_ex_i;
    case (fwd_b_i)
      FWD_EXMEM: op_b = alu_mem_o;
      FWD_WB:    op_b = data_wb_i;
      default:   op_b = rs2_ex_i;
    endcase
  end

  assign alu_a = asel_ex_i ? pc_ex_i  : op_a;
  assign alu_b = bsel_ex_i ? imm_ex_i : op_b;

  alu #(.XLEN(XLEN)) u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .sel (alusel_ex_i),
    .y   (alu_o)
  );

  brcomp #(.XLEN(XLEN)) u_brcomp (
    .a    (op_a),
    .b    (op_b),
    .brun (brun_ex_i),
    .breq (breq_o),
    .brlt (brlt_o)
  );

  if (MD_EN) begin : g_md
    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
      .clk    (clk_i),
      .rst_n  (rst_ni),
      .start  (md_valid_i),
      .kill   (flush_i),
      .ack    (enable_i),
      .op     (md_op_i),
      .a      (op_a),
      .b      (op_b),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_result)
    );
  end else begin : g_no_md
    assign md_busy   = 1'b0;
    assign md_done   = 1'b0;
    assign md_result = '0;
  end

  assign stall_o = md_busy;

  always_comb begin
    exmem_d.alu    = md_done ? md_result : alu_o;
    exmem_d.rs2    = op_b;
    exmem_d.pc4    = pc4_ex_i;
    exmem_d.memrw  = memrw_ex_i;
    exmem_d.regwen = regwen_ex_i;
    exmem_d.wbsel  = wbsel_ex_i;
    exmem_d.rsw    = rsw_ex_i;
    exmem_d.inst   = inst_ex_i;
  end

  // Flush and stall both load an all-zero bubble; hold wins over both.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  exmem_q <= '0;
    else if (enable_i) begin
      if (flush_i || stall_o)     exmem_q <= '0;
      else                        exmem_q <= exmem_d;
    end
  end

  assign alu_mem_o    = exmem_q.alu;
  assign rs2_mem_o    = exmem_q.rs2;
  assign pc4_mem_o    = exmem_q.pc4;
  assign memrw_mem_o  = exmem_q.memrw;
  assign regwen_mem_o = exmem_q.regwen;
  assign wbsel_mem_o  = exmem_q.wbsel;
  assign rsw_mem_o    = exmem_q.rsw;
  assign inst_mem_o   = exmem_q.inst;
endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
- Parametrised execute stage for the 5-stage RV32I/RV32IM pipeline, sitting between the ID/EX and EX/MEM boundaries.
- Contains:
  - operand forwarding muxes;
  - the existing alu and brcomp;
  - an iterative multiply/divide unit (RV32M);
  - the EX/MEM pipeline register with enable, flush and bubble insertion.
- Multi-cycle M-ops hold the front of the pipeline through stall_o.
- Branch compare outputs stay combinational, for redirect in EX.

Parameters:
- XLEN, 32: datapath width. Must be even and ≥8.
- MD_EN, 1: 1 = the muldiv unit is instantiated. 0 = md_valid_i is ignored, stall_o is tied to 0, and md results read 0.
- RSW_W, 5: register-index width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset (see Behaviour)
- rs1_ex_i, rs2_ex_i, imm_ex_i, pc_ex_i, pc4_ex_i  in  XLEN  ID/EX operands
- inst_ex_i  in  32  instruction
- alusel_ex_i  in  4  alu op
- asel_ex_i, bsel_ex_i, brun_ex_i, memrw_ex_i, regwen_ex_i  in  1  controls
- wbsel_ex_i  in  2  writeback select
- rsw_ex_i  in  RSW_W  destination register
- fwd_a_i, fwd_b_i  in  2  forward select: 00 = reg, 01 = EX/MEM alu, 10 = WB data, 11 = reg
- data_wb_i  in  XLEN  WB-stage data
- md_valid_i  in  1  the instruction in EX is an M-op
- md_op_i  in  3  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- enable_i  in  1  EX/MEM register advance
- flush_i  in  1  kill the instruction in EX
- stall_o  out  1  M-op in progress; freeze IF/ID/EX
- breq_o, brlt_o  out  1  branch compare (combinational)
- alu_o  out  XLEN  combinational alu result
- alu_mem_o, rs2_mem_o, pc4_mem_o  out  XLEN  EX/MEM register outputs
- memrw_mem_o, regwen_mem_o  out  1  EX/MEM register outputs
- wbsel_mem_o  out  2  EX/MEM register output
- rsw_mem_o  out  RSW_W  EX/MEM register output
- inst_mem_o  out  32  EX/MEM register output

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset state:
  - all EX/MEM outputs are 0;
  - FSM is in IDLE;
  - stall_o = 0;
  - the iteration counter and the partial remainder/product are 0.
- Forwarding:
  - opA = fwd_a_i mux of {rs1, alu_mem_o, data_wb_i, rs1}. opB is formed the same way.
  - brcomp takes opA/opB.
  - ALU input A = asel ? pc : opA. ALU input B = bsel ? imm : opB.
  - rs2_mem_o captures forwarded opB.
- Muldiv FSM has three states: IDLE, BUSY, DONE.
  - IDLE:
    - If md_valid_i & ~flush_i: latch opA and opB, take their signs per op, load cnt = 0, go to BUSY.
    - stall_o = md_valid_i.
  - BUSY: one radix-2 step per cycle.
    - Multiply: unsigned shift-add on magnitudes to 2·XLEN bits. Sign fix-up happens at the end.
    - Divide: restoring, on magnitudes.
    - cnt increments each cycle. At cnt == XLEN-1, go to DONE.
    - stall_o = 1.
  - DONE:
    - stall_o = 0. The result is muxed in place of the alu result into alu_mem_o.
    - If enable_i: go to IDLE.
    - Else: hold DONE with the result stable.
- Latency: an M-op occupies EX for XLEN+2 cycles (1 accept + XLEN steps + 1 done). stall_o is high for exactly XLEN+1 cycles.
- Result selection:
  - MUL returns the low XLEN bits. MULH, MULHSU and MULHU return the high XLEN bits.
  - DIV and DIVU return the quotient. REM and REMU return the remainder.
  - Remainder sign follows the dividend.
- Corner cases:
  - Divide by zero: quotient is all ones; remainder is the dividend. The FSM still takes the full XLEN+2 cycles.
  - Signed overflow (−2^(XLEN−1) / −1): quotient is the dividend; remainder is 0.
- EX/MEM register update, priority order:
  1. rst_ni = 0 → reset;
  2. enable_i = 0 → hold;
  3. flush_i → load all zeros;
  4. stall_o → load a bubble (all zeros);
  5. otherwise → capture.
- flush_i while BUSY or DONE: FSM goes to IDLE on the next edge, the result is discarded, and stall_o drops that same cycle.
- Async reset mid-operation: FSM returns to IDLE immediately.
- A new md_valid_i arriving in the DONE→IDLE cycle is not accepted until IDLE (no back-to-back overlap).

Decomposition:
- Shared package rv_pkg:
  - md_op_e enum (8 funct3 codes);
  - fwd_sel_e enum (REG, EXMEM, WB);
  - wbsel constants;
  - XLEN default.
- One sub-module, muldiv_iter. It owns the FSM, counter, shift/accumulate datapath and sign fix-up, with ports start/op/a/b/kill → busy/done/result.
- The existing alu and brcomp are reused unchanged.

Test Plan:
- ADD with fwd_a_i = 01, alu_mem_o = 5, rs2 = 7, alusel = ADD → alu_o = 12. Next edge: alu_mem_o = 12, regwen_mem_o copied from input.
- MUL with opA = −3, opB = 7 → stall_o high for 33 cycles. DONE cycle: stall_o = 0. Next edge: alu_mem_o = 0xFFFFFFEB. During stall, regwen_mem_o = 0 (bubble).
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 → 0x40000000.
- DIV 7 by 0 → 0xFFFFFFFF. REM 7 by 0 → 7. DIV 0x80000000 by −1 → 0x80000000. REM −7 by 2 → −1.
- flush_i at BUSY cycle 10 → stall_o = 0 next cycle, FSM in IDLE, EX/MEM all zero. rst_ni low at BUSY cycle 5 → all outputs 0 asynchronously.
- DONE with enable_i = 0 for 3 cycles → EX/MEM held and the result stable. enable_i = 1 → captured once, FSM in IDLE.
